// File: rtl/mem_ctrl_param_if.sv
// Request/response bus between the CPU control unit and the parametrised memory.
interface mem_ctrl_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              en;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] output_data;
    logic              ready;
    logic              busy;
    logic              error;

    modport master (
        output en, read, write, address, input_data,
        input  output_data, ready, busy, error
    );

    modport slave (
        input  en, read, write, address, input_data,
        output output_data, ready, busy, error
    );
endinterface

// File: rtl/mem_ctrl_param.sv
// Single-port synchronous RAM with request/ready handshake, configurable wait
// states, busy flag and error reporting for conflicting or out-of-range requests.
module mem_ctrl_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_ctrl_param_if.slave   bus
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    req_t              req_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] out_q, out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;

    logic              can_accept_c;
    logic              accept_c;
    logic              conflict_c;
    logic              wait_done_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  idx_c;

    // A new request may be taken in IDLE or on the edge that closes RESP.
    assign can_accept_c = (state_q == S_IDLE) || (state_q == S_RESP);
    assign accept_c     = can_accept_c && bus.en && (bus.read ^ bus.write);
    assign conflict_c   = (state_q == S_IDLE) && bus.en && bus.read && bus.write;
    assign wait_done_c  = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
    assign in_range_c   = {1'b0, req_q.addr} < DEPTH_LIM;
    assign idx_c        = req_q.addr[IDX_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept_c) state_d = S_WAIT;
            S_WAIT: if (wait_done_c) state_d = S_RESP;
            S_RESP: state_d = accept_c ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        ready_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
        error_d = conflict_c || (wait_done_c && !in_range_c);
        out_d   = out_q;
        if (wait_done_c && !req_q.wr) begin
            out_d = in_range_c ? mem[idx_c] : '0;
        end
    end

    // Request capture, wait counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            req_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            if (accept_c) begin
                req_q <= '{wr: bus.write, addr: bus.address, data: bus.input_data};
                cnt_q <= '0;
            end else if ((state_q == S_WAIT) && !wait_done_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Storage array is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wait_done_c && req_q.wr && in_range_c) begin
            mem[idx_c] <= req_q.data;
        end
    end

    assign bus.output_data = out_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Self-checking bench for mem_ctrl_param (DATA_W=8, ADDR_W=8, DEPTH=128, LATENCY=2).
module tb_mem_ctrl_param;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] model_mem [128];
    bit         model_vld [128];
    logic [7:0] model_out = 8'h00;

    mem_ctrl_param_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mem_ctrl_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference behaviour: in-range writes store, reads return stored word or 0.
    function automatic void model_op(input bit wr, input int a, input logic [7:0] d,
                                     output logic exp_err, output logic [7:0] exp_out);
        exp_err = (a >= 128);
        if (wr) begin
            if (a < 128) begin
                model_mem[a] = d;
                model_vld[a] = 1'b1;
            end
        end else begin
            model_out = (a < 128) ? model_mem[a] : 8'h00;
        end
        exp_out = model_out;
    endfunction

    // Issue one request, scramble inputs after acceptance, observe the response.
    task automatic access(input bit wr, input int a, input logic [7:0] d,
                          output int lat, output int busy_cyc, output int rdy_cyc,
                          output logic err, output logic [7:0] rdata);
        @(negedge clk);
        bus.en = 1'b1; bus.read = !wr; bus.write = wr;
        bus.address = 8'(a); bus.input_data = d;
        @(posedge clk);
        #1;
        bus.en = 1'b0; bus.read = 1'($urandom); bus.write = 1'($urandom);
        bus.address = 8'($urandom); bus.input_data = 8'($urandom);
        lat = -1; busy_cyc = 0; rdy_cyc = 0; err = 1'b0; rdata = 8'h00;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.ready) begin
                rdy_cyc++;
                if (lat < 0) begin
                    lat = k; err = bus.error; rdata = bus.output_data;
                end
            end
            if (!bus.busy && lat >= 0) break;
        end
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic test_reset();
        int lat, bc, rc; logic err; logic [7:0] rd, exp_o; logic exp_e;
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.ready, bus.busy, bus.error, bus.output_data} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_initial: ready=%b busy=%b error=%b out=%h, want all 0",
                     bus.ready, bus.busy, bus.error, bus.output_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 5, 8'h55, lat, bc, rc, err, rd);
        model_op(1'b1, 5, 8'h55, exp_e, exp_o);
        access(1'b0, 5, 8'h00, lat, bc, rc, err, rd);
        model_op(1'b0, 5, 8'h00, exp_e, exp_o);
        // Interrupt a write of AA to addr 5 while it is waiting
        @(negedge clk);
        bus.en = 1'b1; bus.read = 1'b0; bus.write = 1'b1;
        bus.address = 8'd5; bus.input_data = 8'hAA;
        @(posedge clk);
        #1 bus.en = 1'b0; bus.write = 1'b0;
        @(posedge clk);
        #2;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.output_data !== 8'h55) begin
            n_fail++;
            $display("FAIL reset_pre: busy=%b out=%h, want busy=1 out=55", bus.busy, bus.output_data);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.ready, bus.busy, bus.error, bus.output_data} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_async: ready=%b busy=%b error=%b out=%h, want all 0",
                     bus.ready, bus.busy, bus.error, bus.output_data);
        end
        model_out = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 5, 8'h00, lat, bc, rc, err, rd);
        model_op(1'b0, 5, 8'h00, exp_e, exp_o);
        n_tests++;
        if (rd !== exp_o || err !== exp_e) begin
            n_fail++;
            $display("FAIL reset_discard: read addr5=%h err=%b, want %h err=%b", rd, err, exp_o, exp_e);
        end
    endtask

    task automatic test_write_read();
        int lat, bc, rc, a; bit wr; logic err, exp_e; logic [7:0] rd, exp_o, d;
        for (int i = 0; i < 32; i++) begin
            if (i == 0) begin wr = 1'b1; a = 33; d = 8'h3C; end
            else if (i == 1) begin wr = 1'b0; a = 33; d = 8'h00; end
            else begin
                wr = 1'($urandom);
                a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(128, 255))
                                                 : int'($urandom_range(0, 127));
                d  = 8'($urandom);
                if (!wr && a < 128 && !model_vld[a]) wr = 1'b1;
            end
            access(wr, a, d, lat, bc, rc, err, rd);
            model_op(wr, a, d, exp_e, exp_o);
            n_tests++;
            if (lat !== 2 || bc !== 3 || rc !== 1) begin
                n_fail++;
                $display("FAIL wr_rd_timing[%0d]: lat=%0d busy=%0d rdy=%0d, want 2/3/1", i, lat, bc, rc);
            end
            n_tests++;
            if (err !== exp_e || rd !== exp_o || bus.output_data !== exp_o) begin
                n_fail++;
                $display("FAIL wr_rd_data[%0d] wr=%0b a=%0d: err=%b out=%h hold=%h, want err=%b out=%h",
                         i, wr, a, err, rd, bus.output_data, exp_e, exp_o);
            end
        end
    endtask

    task automatic test_conflict();
        int lat, bc, rc; logic err, exp_e; logic [7:0] rd, exp_o;
        @(negedge clk);
        bus.en = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
        bus.address = 8'd33; bus.input_data = 8'hF0;
        @(posedge clk);
        #1 bus.en = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.output_data !== model_out) begin
            n_fail++;
            $display("FAIL conflict_pulse: error=%b busy=%b ready=%b out=%h, want 1/0/0/%h",
                     bus.error, bus.busy, bus.ready, bus.output_data, model_out);
        end
        @(negedge clk);
        n_tests++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_one_cycle: error=%b busy=%b, want 0/0", bus.error, bus.busy);
        end
        access(1'b0, 33, 8'h00, lat, bc, rc, err, rd);
        model_op(1'b0, 33, 8'h00, exp_e, exp_o);
        n_tests++;
        if (rd !== exp_o || err !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_ram: addr33=%h err=%b, want %h err=0", rd, err, exp_o);
        end
    endtask

    task automatic test_out_of_range();
        int lat, bc, rc; logic err, exp_e; logic [7:0] rd, exp_o;
        access(1'b1, 72, 8'h9E, lat, bc, rc, err, rd);
        model_op(1'b1, 72, 8'h9E, exp_e, exp_o);
        access(1'b1, 200, 8'h11, lat, bc, rc, err, rd);
        model_op(1'b1, 200, 8'h11, exp_e, exp_o);
        n_tests++;
        if (lat !== 2 || rc !== 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write: lat=%0d rdy=%0d err=%b, want 2/1/1", lat, rc, err);
        end
        access(1'b0, 200, 8'h00, lat, bc, rc, err, rd);
        model_op(1'b0, 200, 8'h00, exp_e, exp_o);
        n_tests++;
        if (lat !== 2 || err !== 1'b1 || rd !== 8'h00) begin
            n_fail++;
            $display("FAIL oor_read: lat=%0d err=%b out=%h, want 2/1/00", lat, err, rd);
        end
        access(1'b0, 72, 8'h00, lat, bc, rc, err, rd);
        model_op(1'b0, 72, 8'h00, exp_e, exp_o);
        n_tests++;
        if (rd !== exp_o || err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_no_alias: addr72=%h err=%b, want %h err=0", rd, err, exp_o);
        end
    endtask

    task automatic test_hold();
        int lat, bc, rc; logic err, exp_e; logic [7:0] rd, exp_o;
        access(1'b1, 1, 8'h05, lat, bc, rc, err, rd);
        model_op(1'b1, 1, 8'h05, exp_e, exp_o);
        access(1'b0, 1, 8'h00, lat, bc, rc, err, rd);
        model_op(1'b0, 1, 8'h00, exp_e, exp_o);
        n_tests++;
        if (rd !== 8'h05) begin
            n_fail++;
            $display("FAIL hold_read: out=%h, want 05", rd);
        end
        access(1'b1, 2, 8'hE7, lat, bc, rc, err, rd);
        model_op(1'b1, 2, 8'hE7, exp_e, exp_o);
        n_tests++;
        if (rd !== 8'h05 || bus.output_data !== 8'h05) begin
            n_fail++;
            $display("FAIL hold_write: out_at_ready=%h out_after=%h, want 05", rd, bus.output_data);
        end
    endtask

    task automatic test_back_to_back();
        int n_rdy = 0;
        logic [7:0] exp_o;
        exp_o = model_mem[33];
        @(negedge clk);
        bus.en = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'd33;
        for (int p = 1; p <= 15; p++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (bus.ready !== ((p % 3) == 0) || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_edge[%0d]: ready=%b busy=%b, want ready=%b busy=1",
                         p, bus.ready, bus.busy, (p % 3) == 0);
            end
            if (bus.ready) begin
                n_rdy++;
                n_tests++;
                if (bus.output_data !== exp_o) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: out=%h, want %h", p, bus.output_data, exp_o);
                end
            end
        end
        bus.en = 1'b0; bus.read = 1'b0;
        model_out = exp_o;
        repeat (2) @(negedge clk);
        n_tests++;
        if (n_rdy !== 5 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: pulses=%0d busy=%b, want 5 busy=0", n_rdy, bus.busy);
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = 8'h00; bus.input_data = 8'h00;
        for (int i = 0; i < 128; i++) begin
            model_mem[i] = 8'h00;
            model_vld[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_conflict();
        test_out_of_range();
        test_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
